// File: rtl/inline_pkg.sv
// Shared types and default parameters for the inline responder.
package inline_pkg;

   // Responder control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 4;
   localparam int LAT_DEF   = 2;

endpackage

// File: rtl/inline_resp_fifo.sv
// Request FIFO: count-based full/empty, head entry always presented on dout.
module inline_resp_fifo
   import inline_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Guard against overflow and underflow regardless of the caller
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == '0);
   assign dout  = mem_r[rd_ptr_r];

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1'b1);
            2'b01:   count_r <= count_r - (AW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/inline_resp.sv
// Inline responder: queues requests, processes each for LAT cycles and
// returns data+1 on a valid/ready response channel in arrival order.
module inline_resp
   import inline_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          busy
);

   localparam int CW = $clog2(LAT + 1);

   state_t        state_r;
   state_t        state_nx_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nx_s;
   logic [DW-1:0] work_r;
   logic [DW-1:0] work_nx_s;
   logic          pop_s;
   logic          push_s;
   logic          full_s;
   logic          empty_s;
   logic [DW-1:0] head_s;

   assign push_s = req_valid & ~full_s;

   inline_resp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (req_data),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Outputs decode registered state/count only
   assign req_ready = ~full_s;
   assign rsp_valid = (state_r == RESP);
   assign rsp_data  = work_r;
   assign busy      = (state_r != IDLE) | ~empty_s;

   // Next-state logic; a response handshake with a queued request reloads without an IDLE bubble
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      work_nx_s  = work_r;
      pop_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s      = 1'b1;
               work_nx_s  = head_s + DW'(1'b1);
               cnt_nx_s   = CW'(LAT);
               state_nx_s = PROC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         PROC: begin
            cnt_nx_s = cnt_r - CW'(1'b1);
            if (cnt_r == CW'(1'b1)) begin
               state_nx_s = RESP;
            end else begin
               state_nx_s = PROC;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               if (!empty_s) begin
                  pop_s      = 1'b1;
                  work_nx_s  = head_s + DW'(1'b1);
                  cnt_nx_s   = CW'(LAT);
                  state_nx_s = PROC;
               end else begin
                  state_nx_s = IDLE;
               end
            end else begin
               state_nx_s = RESP;
            end
         end
         default: begin
            state_nx_s = IDLE;
            cnt_nx_s   = '0;
         end
      endcase
   end

   // State, latency counter and work register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         work_r  <= '0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         work_r  <= work_nx_s;
      end
   end

endmodule
